// File: rtl/direct_mapped_cache_pkg.sv
// cache_pkg: shared FSM state type and address-split helpers for the direct-mapped cache.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, RESP} state_t;
  function automatic int index_w(int size);
    return $clog2(size);
  endfunction
  function automatic int tag_w(int addr_width, int size);
    return addr_width - $clog2(size);
  endfunction
endpackage

// File: rtl/direct_mapped_cache_if.sv
// direct_mapped_cache_if: requester-side and memory-side signals of the cache.
interface direct_mapped_cache_if #(parameter int ADDR_WIDTH = 16, parameter int DATA_WIDTH = 8);
  logic cs_input;
  logic we;
  logic oe;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic flush;
  logic [DATA_WIDTH-1:0] cache_data;
  logic ready;
  logic mem_req;
  logic mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic mem_ack;
  modport master (
    output cs_input, we, oe, addr, wdata, flush, mem_rdata, mem_ack,
    input cache_data, ready, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input cs_input, we, oe, addr, wdata, flush, mem_rdata, mem_ack,
    output cache_data, ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/direct_mapped_cache_line_array.sv
// cache_line_array: valid/tag/data storage with combinational lookup, single write port and flush.
module cache_line_array import cache_pkg::*; #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int CACHE_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);
  localparam int IW = index_w(CACHE_SIZE);
  localparam int TW = tag_w(ADDR_WIDTH, CACHE_SIZE);
  logic [CACHE_SIZE-1:0] valid;
  logic [TW-1:0] tags [CACHE_SIZE];
  logic [DATA_WIDTH-1:0] data [CACHE_SIZE];
  logic [IW-1:0] li;
  logic [IW-1:0] wi;
  assign li = lookup_addr[IW-1:0];
  assign wi = wr_addr[IW-1:0];
  assign hit = valid[li] && tags[li] == lookup_addr[ADDR_WIDTH-1:IW];
  assign rdata = data[li];
  always_ff @(posedge clk) begin
    if (rst || flush) valid <= '0;
    else if (wr_en) valid[wi] <= 1'b1;
  end
  // tag/data need no reset: valid gates every use
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wi] <= wr_addr[ADDR_WIDTH-1:IW];
      data[wi] <= wr_data;
    end
  end
endmodule

// File: rtl/direct_mapped_cache.sv
// direct_mapped_cache: write-through, no-write-allocate direct-mapped cache with miss fill and hit/miss counters.
module direct_mapped_cache import cache_pkg::*; #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int CACHE_SIZE = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  direct_mapped_cache_if.slave bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);
  state_t state;
  logic hit;
  logic [DATA_WIDTH-1:0] line_data;
  logic idle;
  logic accept_wr;
  logic accept_rd;
  logic fill;
  logic wr_en;
  assign idle = state == IDLE;
  assign accept_wr = idle && !bus.flush && bus.cs_input && bus.we;
  assign accept_rd = idle && !bus.flush && bus.cs_input && bus.oe && !bus.we;
  assign fill = state == MEM_RD && bus.mem_ack;
  assign wr_en = !rst && (fill || (accept_wr && hit));
  assign bus.ready = state == RESP;
  cache_line_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .CACHE_SIZE(CACHE_SIZE)
  ) u_lines (
    .clk,
    .rst,
    .flush(idle && bus.flush),
    .lookup_addr(bus.addr),
    .hit,
    .rdata(line_data),
    .wr_en,
    .wr_addr(fill ? bus.mem_addr : bus.addr),
    .wr_data(fill ? bus.mem_rdata : bus.wdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.cache_data <= '0;
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_wr) begin
            bus.mem_addr <= bus.addr;
            bus.mem_wdata <= bus.wdata;
            bus.mem_req <= 1'b1;
            bus.mem_we <= 1'b1;
            state <= MEM_WR;
          end else if (accept_rd && hit) begin
            bus.cache_data <= line_data;
            if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
            state <= RESP;
          end else if (accept_rd) begin
            if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
            bus.mem_addr <= bus.addr;
            bus.mem_req <= 1'b1;
            bus.mem_we <= 1'b0;
            state <= MEM_RD;
          end
        end
        MEM_RD: begin
          if (bus.mem_ack) begin
            bus.cache_data <= bus.mem_rdata;
            bus.mem_req <= 1'b0;
            state <= RESP;
          end
        end
        MEM_WR: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            bus.mem_we <= 1'b0;
            state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_direct_mapped_cache.sv
// tb_direct_mapped_cache: table-driven directed vectors plus reset, flush, no-op and saturation sequences.
module tb_direct_mapped_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] hit_count;
  logic [3:0] miss_count;
  int n_checks = 0;
  int n_fail = 0;
  direct_mapped_cache_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();
  direct_mapped_cache #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .CACHE_SIZE(16),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic flush_before;
    logic we;
    logic oe;
    logic [15:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int lat;
    logic [7:0] exp_data;
    logic exp_req;
    logic exp_mwe;
    int exp_cycles;
    logic [3:0] exp_hit;
    logic [3:0] exp_miss;
  } vec_t;
  vec_t vecs[14];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic do_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
  endtask
  task automatic do_txn(input logic we, input logic oe, input logic [15:0] addr, input logic [7:0] wdata,
                        input logic [7:0] rdata, input int lat, output logic [7:0] data, output logic saw_req,
                        output logic req_we, output logic [15:0] req_addr, output logic [7:0] req_wdata,
                        output int cycles);
    int reqc = 0;
    logic done = 1'b0;
    saw_req = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    data = '0;
    cycles = 0;
    @(negedge clk);
    bus.cs_input = 1'b1;
    bus.we = we;
    bus.oe = oe;
    bus.addr = addr;
    bus.wdata = wdata;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.ready) begin
        done = 1'b1;
        cycles = k;
        data = bus.cache_data;
      end else if (bus.mem_req) begin
        reqc++;
        if (!saw_req) begin
          saw_req = 1'b1;
          req_we = bus.mem_we;
          req_addr = bus.mem_addr;
          req_wdata = bus.mem_wdata;
        end
        if (reqc == lat) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = rdata;
        end
      end
    end
    bus.cs_input = 1'b0;
    bus.we = 1'b0;
    bus.oe = 1'b0;
    bus.mem_ack = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL txn_timeout addr=0x%0h: no ready within 40 cycles", addr);
    end
    @(negedge clk);
    check($sformatf("ready_one_cycle addr=0x%0h", addr), 32'(bus.ready), 32'(0));
  endtask
  initial begin
    logic [7:0] data;
    logic saw;
    logic rwe;
    logic [15:0] raddr;
    logic [7:0] rwd;
    int cyc;
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 8'h00, 8'hAA, 3, 8'hAA, 1'b1, 1'b0, 4, 4'd0, 4'd1};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 8'h00, 8'h00, 1, 8'hAA, 1'b0, 1'b0, 1, 4'd1, 4'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0014, 8'h00, 8'h55, 2, 8'h55, 1'b1, 1'b0, 3, 4'd1, 4'd2};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 8'h00, 8'hAA, 1, 8'hAA, 1'b1, 1'b0, 2, 4'd1, 4'd3};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0014, 8'h00, 8'h55, 1, 8'h55, 1'b1, 1'b0, 2, 4'd1, 4'd4};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0014, 8'h3C, 8'h00, 2, 8'h55, 1'b1, 1'b1, 3, 4'd1, 4'd4};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h0014, 8'h00, 8'h00, 1, 8'h3C, 1'b0, 1'b0, 1, 4'd2, 4'd4};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0020, 8'h77, 8'h00, 1, 8'h3C, 1'b1, 1'b1, 2, 4'd2, 4'd4};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h0020, 8'h00, 8'h77, 1, 8'h77, 1'b1, 1'b0, 2, 4'd2, 4'd5};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'h0014, 8'h00, 8'h3C, 1, 8'h3C, 1'b1, 1'b0, 2, 4'd2, 4'd6};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h0020, 8'h00, 8'h77, 1, 8'h77, 1'b1, 1'b0, 2, 4'd2, 4'd7};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 16'h0014, 8'h00, 8'h00, 1, 8'h3C, 1'b0, 1'b0, 1, 4'd3, 4'd7};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 16'h0014, 8'h99, 8'h00, 1, 8'h3C, 1'b1, 1'b1, 2, 4'd3, 4'd7};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 16'h0014, 8'h00, 8'h00, 1, 8'h99, 1'b0, 1'b0, 1, 4'd4, 4'd7};
    bus.cs_input = 1'b0;
    bus.we = 1'b0;
    bus.oe = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.flush = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_cache_data", 32'(bus.cache_data), 32'(0));
    check("reset_ready", 32'(bus.ready), 32'(0));
    check("reset_mem_req", 32'(bus.mem_req), 32'(0));
    check("reset_mem_we", 32'(bus.mem_we), 32'(0));
    check("reset_mem_addr", 32'(bus.mem_addr), 32'(0));
    check("reset_mem_wdata", 32'(bus.mem_wdata), 32'(0));
    check("reset_hit_count", 32'(hit_count), 32'(0));
    check("reset_miss_count", 32'(miss_count), 32'(0));
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].flush_before) do_flush();
      do_txn(vecs[i].we, vecs[i].oe, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].lat,
             data, saw, rwe, raddr, rwd, cyc);
      check($sformatf("v%0d cache_data", i), 32'(data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d mem_req_seen", i), 32'(saw), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req) begin
        check($sformatf("v%0d mem_we", i), 32'(rwe), 32'(vecs[i].exp_mwe));
        check($sformatf("v%0d mem_addr", i), 32'(raddr), 32'(vecs[i].addr));
        if (vecs[i].exp_mwe) check($sformatf("v%0d mem_wdata", i), 32'(rwd), 32'(vecs[i].wdata));
      end
      check($sformatf("v%0d latency", i), 32'(cyc), 32'(vecs[i].exp_cycles));
      check($sformatf("v%0d hit_count", i), 32'(hit_count), 32'(vecs[i].exp_hit));
      check($sformatf("v%0d miss_count", i), 32'(miss_count), 32'(vecs[i].exp_miss));
    end
    @(negedge clk);
    bus.cs_input = 1'b1;
    bus.addr = 16'h0014;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("noop_ready c%0d", k), 32'(bus.ready), 32'(0));
      check($sformatf("noop_mem_req c%0d", k), 32'(bus.mem_req), 32'(0));
    end
    bus.cs_input = 1'b0;
    check("noop_hit_count", 32'(hit_count), 32'(4));
    check("noop_miss_count", 32'(miss_count), 32'(7));
    @(negedge clk);
    bus.cs_input = 1'b1;
    bus.oe = 1'b1;
    bus.addr = 16'h0030;
    @(negedge clk);
    check("midrd_mem_req", 32'(bus.mem_req), 32'(1));
    rst = 1'b1;
    bus.cs_input = 1'b0;
    bus.oe = 1'b0;
    @(negedge clk);
    check("midrst_mem_req", 32'(bus.mem_req), 32'(0));
    check("midrst_ready", 32'(bus.ready), 32'(0));
    check("midrst_hit_count", 32'(hit_count), 32'(0));
    check("midrst_miss_count", 32'(miss_count), 32'(0));
    rst = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'hEE;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("late_ack_ready c%0d", k), 32'(bus.ready), 32'(0));
      check($sformatf("late_ack_mem_req c%0d", k), 32'(bus.mem_req), 32'(0));
      @(negedge clk);
    end
    do_txn(1'b0, 1'b1, 16'h0030, 8'h00, 8'h12, 1, data, saw, rwe, raddr, rwd, cyc);
    check("post_rst_miss_req", 32'(saw), 32'(1));
    check("post_rst_data", 32'(data), 32'(8'h12));
    check("post_rst_miss_count", 32'(miss_count), 32'(1));
    for (int i = 0; i < 17; i++) begin
      do_txn(1'b0, 1'b1, 16'h1000 + 16'(i << 4), 8'h00, 8'(i), 1, data, saw, rwe, raddr, rwd, cyc);
      check($sformatf("sat_miss_count m%0d", i), 32'(miss_count), (i + 2 > 15) ? 32'(15) : 32'(i + 2));
    end
    check("sat_final_miss_count", 32'(miss_count), 32'(4'hF));
    check("sat_hit_count", 32'(hit_count), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/direct_mapped_cache.md
Name: direct_mapped_cache

Overview:
- Parametrised successor to the immediate cache: direct-mapped, one word per line, with valid/tag arrays and a real miss path.
- Sits between a CPU-side requester and backing memory.
- Read misses fill from memory over a req/ack handshake. Writes are write-through, no-write-allocate.
- Adds a single-cycle flush and saturating hit/miss counters for performance monitoring.

Parameters:
- ADDR_WIDTH, 16, byte/word address width.
- DATA_WIDTH, 8, data word width.
- CACHE_SIZE, 16, number of lines; power of two, >= 2.
- CNT_WIDTH, 16, width of hit/miss counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cs_input  in  1  request strobe; requester holds it high until ready.
- we  in  1  write request.
- oe  in  1  read request.
- addr  in  ADDR_WIDTH  request address.
- wdata  in  DATA_WIDTH  write data.
- flush  in  1  invalidate all lines.
- cache_data  out  DATA_WIDTH  read data, valid when ready=1.
- ready  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write (1) / read (0).
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- hit_count  out  CNT_WIDTH  read hits, saturating.
- miss_count  out  CNT_WIDTH  read misses, saturating.

Behaviour:
- Address split: INDEX_W=$clog2(CACHE_SIZE); index=addr[INDEX_W-1:0]; tag=addr[ADDR_WIDTH-1:INDEX_W].
- Reset: all valid bits cleared; FSM to IDLE; cache_data=0; ready=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; counters=0.
- Reset mid-operation: FSM to IDLE, mem_req dropped, no line update. A late mem_ack is ignored.
- Tag/data arrays need no reset.
- FSM states: IDLE, MEM_RD, MEM_WR, RESP.
- IDLE priority: flush > write > read.
  - flush=1: all valid bits cleared this cycle; no request captured; stay IDLE.
  - cs_input&&we: capture addr/wdata, assert mem_req/mem_we=1 next cycle, go MEM_WR. If the line hits, its data is updated at capture; if it misses, no allocate.
  - cs_input&&oe&&!we on a hit: cache_data<=line data, hit_count++, go RESP.
  - cs_input&&oe&&!we on a miss: miss_count++, mem_req=1, mem_we=0, mem_addr=addr, go MEM_RD.
  - cs_input with neither we nor oe: no action.
- MEM_RD: hold mem_req until mem_ack. On mem_ack: write line (valid=1, tag, data=mem_rdata), cache_data<=mem_rdata, mem_req<=0, go RESP.
- MEM_WR: hold mem_req/mem_we until mem_ack. Then drop both, go RESP.
- RESP: ready=1 for exactly one cycle, then IDLE. cache_data holds its value until the next read completes.
- Latency:
  - read hit: ready one cycle after acceptance (2-cycle throughput).
  - read miss: ready one cycle after mem_ack.
  - write: ready one cycle after mem_ack.
- Inputs changing while busy are ignored; captured request registers drive mem_addr/mem_wdata.
- flush while not in IDLE is ignored; requester must hold flush until the block is IDLE.
- Requester must deassert or change cs_input the cycle after ready, otherwise the request is re-accepted.
- Counters saturate at all-ones; no wrap-around.
- mem_ack in IDLE/RESP is ignored.

Decomposition:
- Package cache_pkg: state enum (IDLE, MEM_RD, MEM_WR, RESP) and localparam helper functions for INDEX_W/TAG_W.
- One sub-module: cache_line_array. It holds the valid/tag/data arrays with a combinational lookup (hit, rdata), a write-port fill/update, and flush-clear.
- FSM, request capture and counters live in the top level.

Test Plan:
- Reset, then read addr 0x0004 with memory returning 0xAA after 3 cycles -> mem_req with mem_addr=0x0004, mem_we=0; ready one cycle after ack; cache_data=0xAA; miss_count=1.
- Re-read 0x0004 -> no mem_req; ready one cycle after acceptance; cache_data=0xAA; hit_count=1.
- Read 0x0014 (same index, different tag), memory returns 0x55 -> miss, line replaced. Then reading 0x0004 misses again; miss_count=3.
- Write 0x0014 with wdata=0x3C after it is cached -> mem_we=1, mem_wdata=0x3C; ready after ack. Next read of 0x0014 hits with 0x3C.
- Write to uncached 0x0020 -> memory written; no allocate; a following read of 0x0020 misses.
- Pulse flush, then read 0x0014 -> miss. Separately, assert rst during MEM_RD -> mem_req=0 next cycle; late ack ignored; ready stays 0; counters=0.
- Preload miss_count near all-ones (CNT_WIDTH=4), issue 17 misses -> miss_count holds at 0xF.
